// File: rtl/vga_pkg.sv
// Timing, state, colour and pixel definitions shared by the VGA stream scheduler slice.
package vga_pkg;
    localparam int HFP    = 40;
    localparam int HPULSE = 48;
    localparam int HBP    = 40;
    localparam int VFP    = 13;
    localparam int VPULSE = 3;
    localparam int VBP    = 29;
    localparam int HBLANK = HFP + HPULSE + HBP;
    localparam int VBLANK = VFP + VPULSE + VBP;
    localparam int CNT_W  = 12;

    typedef logic [23:0] pixel_t;

    localparam pixel_t WHITE = 24'hFFFFFF;
    localparam pixel_t BLACK = 24'h000000;
    localparam pixel_t RED   = 24'hFF0000;

    typedef enum logic [1:0] {IDLE, WAIT_SOF, STREAM, RESYNC} state_t;

    // Only the low nibble of x/y decides the 16-pixel grid.
    function automatic pixel_t grid_pixel(input logic [3:0] x, input logic [3:0] y);
        return ((x == 4'd0) || (y == 4'd0)) ? WHITE : BLACK;
    endfunction
endpackage

// File: rtl/vga_stream_sched_if.sv
// Read side of the first-word-fall-through pixel FIFO feeding the scheduler.
interface vga_stream_sched_if;
    import vga_pkg::*;

    // fifo_rdata is valid whenever fifo_rempty is low; a word is consumed on
    // every pixel_clk edge where fifo_rinc is high, and fifo_rinc is only
    // raised while fifo_rempty is low.
    pixel_t fifo_rdata;
    logic   fifo_rempty;
    logic   fifo_rinc;

    modport master (input fifo_rdata, input fifo_rempty, output fifo_rinc);
    modport slave  (output fifo_rdata, output fifo_rempty, input fifo_rinc);
endinterface

// File: rtl/vga_raster_cnt.sv
// Horizontal/vertical raster counters with combinational sync, active and frame-boundary flags.
module vga_raster_cnt
    import vga_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [CNT_W-1:0] o_h,
    output logic [CNT_W-1:0] o_v,
    output logic             o_active,
    output logic             o_hs_n,
    output logic             o_vs_n,
    output logic             o_fb
);
    localparam int HTOTAL = HDISP + HBLANK;
    localparam int VTOTAL = VDISP + VBLANK;

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             w_h_wrap;
    logic             w_v_wrap;

    assign w_h_wrap = (r_h == CNT_W'(HTOTAL - 1));
    assign w_v_wrap = (r_v == CNT_W'(VTOTAL - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h <= '0;
            r_v <= '0;
        end else begin
            r_h <= w_h_wrap ? '0 : r_h + CNT_W'(1);
            if (w_h_wrap) begin
                r_v <= w_v_wrap ? '0 : r_v + CNT_W'(1);
            end
        end
    end

    assign o_h      = r_h;
    assign o_v      = r_v;
    assign o_active = (r_h >= CNT_W'(HBLANK)) && (r_v >= CNT_W'(VBLANK));
    assign o_hs_n   = !((r_h >= CNT_W'(HFP)) && (r_h < CNT_W'(HFP + HPULSE)));
    assign o_vs_n   = !((r_v >= CNT_W'(VFP)) && (r_v < CNT_W'(VFP + VPULSE)));
    assign o_fb     = w_h_wrap && w_v_wrap;
endmodule

// File: rtl/vga_stream_sched.sv
// Pixel-domain scheduler: picks FIFO pixels or a fallback pattern for each raster cycle,
// aligns streaming to frame start and recovers from FIFO underflow via a frame resync.
module vga_stream_sched
    import vga_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int UFW   = 16
) (
    input  logic                      pixel_clk,
    input  logic                      pixel_rst,
    input  logic                      enable,
    vga_stream_sched_if.master        fifo,
    output logic                      hs,
    output logic                      vs,
    output logic                      blank,
    output pixel_t                    rgb,
    output logic                      sof,
    output logic                      resync_req,
    output logic                      streaming,
    output logic [UFW-1:0]            underflow_cnt
);
    logic [CNT_W-1:0] w_h;
    logic [CNT_W-1:0] w_v;
    logic             w_active;
    logic             w_hs_n;
    logic             w_vs_n;
    logic             w_fb;
    logic [3:0]       w_x_lo;
    logic [3:0]       w_y_lo;
    logic             w_pop;
    logic             w_underflow;

    state_t           r_state;
    logic             r_hs;
    logic             r_vs;
    logic             r_blank;
    pixel_t           r_rgb;
    logic             r_sof;
    logic             r_resync;
    logic [UFW-1:0]   r_ucnt;

    vga_raster_cnt #(.HDISP(HDISP), .VDISP(VDISP)) u_raster (
        .i_clk    (pixel_clk),
        .i_rst    (pixel_rst),
        .o_h      (w_h),
        .o_v      (w_v),
        .o_active (w_active),
        .o_hs_n   (w_hs_n),
        .o_vs_n   (w_vs_n),
        .o_fb     (w_fb)
    );

    assign w_x_lo = 4'(w_h - CNT_W'(HBLANK));
    assign w_y_lo = 4'(w_v - CNT_W'(VBLANK));

    // Pop strobe is combinational so the FWFT head is consumed on the edge that registers it.
    assign w_pop       = (r_state == STREAM) && w_active && !fifo.fifo_rempty && !pixel_rst;
    assign w_underflow = (r_state == STREAM) && w_active && fifo.fifo_rempty;
    assign fifo.fifo_rinc = w_pop;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_state  <= IDLE;
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
            r_blank  <= 1'b0;
            r_rgb    <= BLACK;
            r_sof    <= 1'b0;
            r_resync <= 1'b0;
            r_ucnt   <= '0;
        end else begin
            r_hs     <= w_hs_n;
            r_vs     <= w_vs_n;
            r_blank  <= w_active;
            r_sof    <= (w_h == '0) && (w_v == '0);
            r_resync <= w_underflow;

            if (!w_active) begin
                r_rgb <= BLACK;
            end else begin
                case (r_state)
                    IDLE, WAIT_SOF: r_rgb <= grid_pixel(w_x_lo, w_y_lo);
                    STREAM:         r_rgb <= w_underflow ? RED : fifo.fifo_rdata;
                    default:        r_rgb <= BLACK;
                endcase
            end

            if (w_underflow && (r_ucnt != '1)) begin
                r_ucnt <= r_ucnt + UFW'(1);
            end

            // Underflow outranks the frame-boundary exit so a late underflow still resyncs.
            case (r_state)
                IDLE: begin
                    if (enable) r_state <= WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (w_fb) begin
                        if (!enable)                 r_state <= IDLE;
                        else if (!fifo.fifo_rempty)  r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_underflow)           r_state <= RESYNC;
                    else if (w_fb && !enable)  r_state <= IDLE;
                end
                RESYNC: begin
                    if (w_fb) r_state <= WAIT_SOF;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign hs            = r_hs;
    assign vs            = r_vs;
    assign blank         = r_blank;
    assign rgb           = r_rgb;
    assign sof           = r_sof;
    assign resync_req    = r_resync;
    assign streaming     = (r_state == STREAM);
    assign underflow_cnt = r_ucnt;
endmodule

// File: tb/tb_vga_stream_sched.sv
// Scoreboard bench for vga_stream_sched on a shrunken raster, plus a narrow-counter
// instance that is driven into repeated underflows.
module tb_vga_stream_sched;
    import vga_pkg::*;

    localparam int HD = 20;
    localparam int VD = 6;
    localparam int HT = HD + 128;
    localparam int VT = VD + 45;
    localparam int FR = HT * VT;
    localparam int NPIX = HD * VD;
    localparam int M_GRID = 0;
    localparam int M_STREAM = 1;
    localparam int M_UF = 2;
    localparam int UX = 10;
    localparam int UY = 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic rst2 = 1'b1;
    logic en2 = 1'b0;
    always #5 clk = ~clk;

    logic hs, vs, blank, sof, resync, strm;
    pixel_t rgb;
    logic [15:0] ucnt;
    logic hs2, vs2, blank2, sof2, resync2, strm2;
    pixel_t rgb2;
    logic [1:0] ucnt2;

    vga_stream_sched_if fif();
    vga_stream_sched_if fif2();

    vga_stream_sched #(.HDISP(HD), .VDISP(VD), .UFW(16)) dut (
        .pixel_clk(clk), .pixel_rst(rst), .enable(en), .fifo(fif),
        .hs(hs), .vs(vs), .blank(blank), .rgb(rgb), .sof(sof),
        .resync_req(resync), .streaming(strm), .underflow_cnt(ucnt)
    );

    vga_stream_sched #(.HDISP(4), .VDISP(1), .UFW(2)) dut2 (
        .pixel_clk(clk), .pixel_rst(rst2), .enable(en2), .fifo(fif2),
        .hs(hs2), .vs(vs2), .blank(blank2), .rgb(rgb2), .sof(sof2),
        .resync_req(resync2), .streaming(strm2), .underflow_cnt(ucnt2)
    );

    // The narrow instance sees data only while its own previous output cycle was active,
    // so it enters STREAM at each frame boundary and underflows on the first pixel.
    assign fif2.fifo_rdata  = 24'h123456;
    assign fif2.fifo_rempty = !blank2;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // driver: FIFO model and expected-pixel queue
    pixel_t fifo_q[$];
    logic [23:0] exp_q[$];
    logic force_empty = 1'b0;

    task automatic drive_fifo();
        fif.fifo_rempty = (fifo_q.size() == 0) || force_empty;
        fif.fifo_rdata  = (fifo_q.size() == 0) ? BLACK : fifo_q[0];
    endtask

    task automatic load_frame(input pixel_t base);
        for (int i = 0; i < NPIX; i++) begin
            fifo_q.push_back(base + pixel_t'(i));
            exp_q.push_back(base + pixel_t'(i));
        end
        drive_fifo();
    endtask

    function automatic logic [23:0] next_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    int pos = 0;
    bit running = 1'b0;
    logic pre_rinc = 1'b0;
    int pops[16];
    int mode[16];

    always @(negedge clk) begin
        #4;
        pre_rinc = fif.fifo_rinc;
    end

    always @(posedge clk) begin
        if (running) begin
            if (pre_rinc) pops[pos / FR]++;
            pos++;
            if (pre_rinc) begin
                #1;
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
                drive_fifo();
            end
        end
    end

    // monitor: every output cycle is compared against the raster position it reflects
    always @(negedge clk) begin : mon
        int p, f, q, h, v, x, y;
        bit act;
        logic e_hs, e_vs, e_sof, e_rs;
        logic [23:0] er;
        if (running && pos > 0) begin
            p = pos - 1;
            f = p / FR;
            q = p % FR;
            h = q % HT;
            v = q / HT;
            act = (h >= 128) && (v >= 45);
            x = h - 128;
            y = v - 45;
            e_hs = !((h >= 40) && (h < 88));
            e_vs = !((v >= 13) && (v < 16));
            e_sof = (q == 0);
            e_rs = 1'b0;
            er = 24'h000000;
            if (act) begin
                case (mode[f])
                    M_GRID:   er = ((x % 16 == 0) || (y % 16 == 0)) ? 24'hFFFFFF : 24'h000000;
                    M_STREAM: er = next_exp();
                    default: begin
                        if ((y < UY) || (y == UY && x < UX)) er = next_exp();
                        else if (y == UY && x == UX) begin
                            er = 24'hFF0000;
                            e_rs = 1'b1;
                        end
                    end
                endcase
            end
            check("video", {hs, vs, blank, sof, resync, rgb}, {e_hs, e_vs, act, e_sof, e_rs, er});
        end
    end

    int k2 = 0;
    always @(negedge clk) begin
        if (!rst2 && resync2) begin
            k2++;
            check("sat_cnt", 64'(ucnt2), (k2 > 3) ? 64'd3 : 64'(k2));
        end
    end

    function automatic int at(input int f, input int x, input int y);
        return f * FR + (y + 45) * HT + x + 128;
    endfunction

    task automatic wait_pos(input int p);
        while (pos < p) @(negedge clk);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) begin
            mode[i] = M_GRID;
            pops[i] = 0;
        end
        drive_fifo();
        #12;
        check("reset_flags", {hs, vs, blank, sof, resync, strm}, 6'b110000);
        check("reset_rgb", rgb, 24'h0);
        check("reset_ucnt", ucnt, 16'h0);
        check("reset_rinc", fif.fifo_rinc, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        rst2 = 1'b0;
        en2 = 1'b1;
        running = 1'b1;

        wait_pos(at(1, 16, 5) + 1);
        check("grid_16_5", rgb, 24'hFFFFFF);
        wait_pos(at(1, 17, 5) + 1);
        check("grid_17_5", rgb, 24'h000000);
        wait_pos(2 * FR + 1);
        check("pops_f0", pops[0], 0);
        check("pops_f1", pops[1], 0);

        wait_pos(2 * FR + 20 * HT);
        en = 1'b1;
        load_frame(24'h100000);
        mode[3] = M_STREAM;
        wait_pos(3 * FR + 1);
        check("sof_f3", sof, 1'b1);
        check("pops_f2", pops[2], 0);
        check("streaming_f3", strm, 1'b1);
        wait_pos(at(3, 0, 0) + 1);
        check("first_word", rgb, 24'h100000);

        wait_pos(4 * FR + 10);
        check("pops_f3", pops[3], NPIX);
        load_frame(24'h200000);
        mode[4] = M_UF;
        wait_pos(at(4, UX, UY));
        force_empty = 1'b1;
        drive_fifo();
        @(negedge clk);
        force_empty = 1'b0;
        drive_fifo();
        check("uf_rgb", rgb, 24'hFF0000);
        check("uf_cnt", ucnt, 16'd1);
        check("uf_resync", resync, 1'b1);
        check("uf_streaming", strm, 1'b0);
        @(negedge clk);
        check("resync_one_pulse", resync, 1'b0);

        wait_pos(5 * FR + 10);
        check("pops_f4", pops[4], UY * HD + UX);
        check("wait_sof_f5", strm, 1'b0);
        fifo_q.delete();
        exp_q.delete();
        load_frame(24'h300000);
        mode[6] = M_STREAM;
        wait_pos(6 * FR + 1);
        check("restream_f6", strm, 1'b1);
        check("pops_f5", pops[5], 0);

        wait_pos(6 * FR + 48 * HT);
        en = 1'b0;
        wait_pos(6 * FR + 50 * HT);
        check("still_streaming", strm, 1'b1);
        wait_pos(7 * FR + 10);
        check("pops_f6", pops[6], NPIX);
        check("idle_f7", strm, 1'b0);

        wait_pos(7 * FR + 14 * HT + 60);
        #2;
        running = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_flags", {hs, vs, blank, sof, resync, strm}, 6'b110000);
        check("async_rst_rgb", rgb, 24'h0);
        check("async_rst_ucnt", ucnt, 16'h0);
        check("async_rst_rinc", fif.fifo_rinc, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_rinc", fif.fifo_rinc, 1'b0);
        for (int i = 0; i < 16; i++) begin
            mode[i] = M_GRID;
            pops[i] = 0;
        end
        rst = 1'b0;
        pos = 0;
        running = 1'b1;
        n = 0;
        while (n < 300 && hs !== 1'b0) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("hs_fall_after_reset", n, 41);

        for (int i = 0; i < 20000 && k2 < 5; i++) @(negedge clk);
        check("sat_underflows", k2, 5);
        check("sat_hold", ucnt2, 2'd3);
        check("pops_after_reset", pops[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_stream_sched.md
Name: vga_stream_sched

Overview:
- Pixel-domain scheduler that sequences the VGA raster and decides, cycle by cycle, what drives the RGB output: the framebuffer pixel FIFO or a fallback pattern.
- Owns the raster counters and the sync generation.
- Pops a first-word-fall-through (FWFT) pixel FIFO in lockstep with active video.
- Aligns stream start to frame start, detects underflow and requests an upstream frame resync.

Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- UFW, 16, width of the saturating underflow counter

Ports:
- pixel_clk  in  1  pixel clock
- pixel_rst  in  1  reset, asynchronous, active-high
- enable  in  1  request streaming from the FIFO
- fifo_rdata  in  24  FWFT head word {R,G,B}; valid whenever fifo_rempty=0
- fifo_rempty  in  1  FIFO empty
- fifo_rinc  out  1  pop strobe, combinational
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- blank  out  1  high during active video
- rgb  out  24  pixel colour
- sof  out  1  one-cycle pulse aligned with the first output cycle of a frame
- resync_req  out  1  one-cycle pulse asking the writer to restart at frame start
- streaming  out  1  state==STREAM
- underflow_cnt  out  UFW  saturating count of underflow events

Behaviour:
- Timing constants:
  - HFP=40, HPULSE=48, HBP=40, HTOTAL=HDISP+128 (928).
  - VFP=13, VPULSE=3, VBP=29, VTOTAL=VDISP+45 (525).
- Raster counters:
  - h runs 0..HTOTAL-1 and wraps to 0.
  - v increments when h wraps; v runs 0..VTOTAL-1 and wraps to 0.
- Active video: h>=128 and v>=45. Pixel column x=h-128, line y=v-45.
- Output registration:
  - Every output except fifo_rinc is registered.
  - Each registered output reflects the counter value present before the same edge, so outputs lag the counters by 1 cycle.
- Sync and blank:
  - hs=0 iff HFP<=h<HFP+HPULSE.
  - vs=0 iff VFP<=v<VFP+VPULSE.
  - blank=active.
- sof=1 for the output cycle corresponding to h=0,v=0.
- Frame boundary (FB): the cycle in which h=HTOTAL-1 and v=VTOTAL-1.
- State machine (enum in package), reset state IDLE:
  - IDLE:
    - fifo_rinc=0.
    - Active video shows the grid pattern: rgb=FFFFFF if x%16==0 or y%16==0, else 000000.
    - Goes to WAIT_SOF when enable=1.
  - WAIT_SOF:
    - Grid pattern, fifo_rinc=0.
    - At FB: goes to STREAM if enable=1 and fifo_rempty=0; goes to IDLE if enable=0; otherwise stays.
  - STREAM:
    - In active video: fifo_rinc=!fifo_rempty, and rgb<=fifo_rdata on the same edge.
    - Active cycle with fifo_rempty=1 (underflow): rgb<=FF0000, underflow_cnt++ (saturating at all-ones), resync_req pulses, state goes to RESYNC.
    - At FB with enable=0: goes to IDLE after finishing the current frame.
    - Outside active video: rgb=000000, fifo_rinc=0.
  - RESYNC:
    - fifo_rinc=0, active video rgb=000000.
    - At FB: goes to WAIT_SOF.
- Outside active video, rgb=000000 in every state.
- Simultaneous events:
  - Underflow on the last active pixel of a frame still goes to RESYNC; the following FB then takes RESYNC to WAIT_SOF.
  - enable dropping mid-frame never truncates the frame in progress.
- Reset, including mid-frame:
  - Counters go to 0 and the state goes to IDLE.
  - hs=1, vs=1, blank=0, rgb=0, sof=0, resync_req=0, streaming=0, underflow_cnt=0.
  - fifo_rinc=0 while reset is asserted.
- Pops per fully streamed frame: exactly HDISP*VDISP.

Decomposition:
- Package vga_pkg holds:
  - timing localparams (HFP, HPULSE, HBP, VFP, VPULSE, VBP)
  - state enum (IDLE, WAIT_SOF, STREAM, RESYNC)
  - colour constants (WHITE, BLACK, RED)
  - a pixel_t typedef (24 bits)
- Sub-module vga_raster_cnt:
  - Contains the h/v counters.
  - Outputs h, v, active, hs_n, vs_n and fb, all combinational from the counters.
- vga_stream_sched holds the FSM, the pop logic and the output registers.

Test Plan:
- Reset then enable=0 for 2 frames:
  - hs low for 48 cycles starting at h=40, vs low for 3 lines starting at v=13.
  - blank high for 800x480 cycles per frame.
  - Grid pixel (x=16,y=5) is FFFFFF, (x=17,y=5) is 000000.
  - fifo_rinc never asserted.
- enable=1 mid-frame with a FIFO preloaded with an incrementing pattern:
  - No pop until FB, then sof pulses.
  - rgb at x=0,y=0 equals the first word; exactly 384000 pops per frame; streaming=1.
- Force fifo_rempty=1 at x=100,y=10:
  - rgb=FF0000 for that pixel, underflow_cnt=1, one resync_req pulse.
  - Rest of the frame is black with no pops.
  - WAIT_SOF is entered at the next FB, and STREAM is re-entered at the following FB.
- Drop enable at y=200 while streaming:
  - Pops continue to the end of the frame, then IDLE and the grid pattern at the next frame.
- Assert pixel_rst at h=500,v=300:
  - Outputs take their reset values immediately, asynchronously.
  - After release, h=0/v=0 restart and hs first falls 41 cycles later.
- Preset underflow_cnt near saturation (UFW=2 build) and cause 5 underflows:
  - underflow_cnt holds at 3.
